// File: rtl/eta_ctrl_pkg.sv
// Shared types and helpers for the approximate-adder arbiter.
// Controller states, datapath widths and round-robin pointer step.
package eta_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RES_W  = 33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int unsigned rr_next(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/error_tolerant_type2_adder32.sv
// ETA-II approximate adder: eight 4-bit segments, each fed by a
// carry generated from the segment below only (no ripple chain).
module error_tolerant_type2_adder32 (
  input  logic [31:0] add1_i,
  input  logic [31:0] add2_i,
  output logic [32:0] sum_o
);

  localparam int unsigned SEGS = 8;

  logic [SEGS-1:0] cin;

  assign cin[0] = 1'b0;

  for (genvar g = 0; g < SEGS; g++) begin : g_seg
    assign sum_o[4*g +: 4] = add1_i[4*g +: 4]
                           + add2_i[4*g +: 4]
                           + {3'b000, cin[g]};
    if (g < SEGS - 1) begin : g_cgen
      assign cin[g+1] = ({1'b0, add1_i[4*g +: 4]}
                       + {1'b0, add2_i[4*g +: 4]}) > 5'd15;
    end
  end

  assign sum_o[32] = ({1'b0, add1_i[31:28]}
                    + {1'b0, add2_i[31:28]}
                    + {4'b0000, cin[SEGS-1]}) > 5'd15;

endmodule

// File: rtl/eta2_add32_arbiter_rr_arbiter.sv
// Round-robin grant: first valid bit at or above ptr_i, wrapping.
// Combinational; the pointer is owned by the caller.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic          found;
  logic [IW-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IW'((32'(ptr_i) + k) % N);
      if (!found && valid_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/eta2_add32_arbiter.sv
// Shares one ETA-II adder among NUM_REQ requesters (IDLE/CALC/RESP).
// Define ERROR_MONITOR_EN to add exact-sum compare and mismatch counter.
module eta2_add32_arbiter
  import eta_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_add1_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_add2_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [RES_W-1:0]          rsp_result_o,
  output logic [ID_W-1:0]           rsp_id_o,
  output logic                      rsp_mismatch_o,
  output logic [CNT_W-1:0]          err_cnt_o
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   op_id_q, op_id_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [RES_W-1:0]  rsp_res_q, rsp_res_d;
  logic              rsp_vld_q, rsp_vld_d;
  logic [RES_W-1:0]  sum;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              accept_ok;
  logic              xfer;
  logic [DATA_W-1:0] a_arr [NUM_REQ];
  logic [DATA_W-1:0] b_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_add1_i[i*DATA_W +: DATA_W];
    assign b_arr[i] = req_add2_i[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx)
  );

  // Adder sees only registered operands: no req_* to rsp_* path.
  error_tolerant_type2_adder32 u_add (
    .add1_i (op_a_q),
    .add2_i (op_b_q),
    .sum_o  (sum)
  );

  assign accept_ok = rst_ni
                   & ((state_q == IDLE)
                   | ((state_q == RESP) & rsp_ready_i));
  assign req_ready_o = accept_ok ? gnt : '0;
  assign xfer        = |req_ready_o;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_id_d   = op_id_q;
    rsp_vld_d = rsp_vld_q;
    rsp_res_d = rsp_res_q;
    rsp_id_d  = rsp_id_q;
    if (xfer) begin
      ptr_d   = ID_W'(rr_next(32'(gnt_idx), NUM_REQ));
      op_a_d  = a_arr[gnt_idx];
      op_b_d  = b_arr[gnt_idx];
      op_id_d = gnt_idx;
    end
    unique case (state_q)
      IDLE: begin
        if (xfer) state_d = CALC;
      end
      CALC: begin
        rsp_res_d = sum;
        rsp_id_d  = op_id_q;
        rsp_vld_d = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_vld_d = 1'b0;
          state_d   = xfer ? CALC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_id_q   <= '0;
      rsp_vld_q <= 1'b0;
      rsp_res_q <= '0;
      rsp_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_id_q   <= op_id_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_res_q <= rsp_res_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

  assign rsp_valid_o  = rsp_vld_q;
  assign rsp_result_o = rsp_res_q;
  assign rsp_id_o     = rsp_id_q;

`ifdef ERROR_MONITOR_EN
  logic [RES_W-1:0] exact;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign exact = {1'b0, op_a_q} + {1'b0, op_b_q};

  always_comb begin
    mis_d = mis_q;
    cnt_d = cnt_q;
    if (state_q == CALC) begin
      mis_d = (exact != sum);
      if (mis_d && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mis_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      mis_q <= mis_d;
      cnt_q <= cnt_d;
    end
  end

  assign rsp_mismatch_o = mis_q;
  assign err_cnt_o      = cnt_q;
`else
  assign rsp_mismatch_o = 1'b0;
  assign err_cnt_o      = '0;
`endif

endmodule
